fc_layer_sequencer: RTL and testbench

Sequencer for one fully-connected MNIST layer built on the four-lane `mac_controller`. It walks the feature and weight memories word by word, drives the MAC's `en`/`flush`/`valid`/`last_in` controls, and waits for the MAC's `done` pulse. On each `done` it captures the neuron result, writes it to the result memory, and tracks the running argmax so the predicted class is available when the layer finishes.

---
 rtl/mnist_pkg.sv | 40 ++++
 rtl/fc_layer_sequencer_if.sv | 32 +++
 rtl/fc_addr_gen.sv | 102 ++++++++++
 rtl/fc_layer_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_pkg.sv
// ---------------------------------------------------------------------------
// mnist_pkg
// Shared definitions for the fully-connected layer sequencer:
//   - seq_state_e : sequencer FSM state encoding
//   - ACC_W       : MAC accumulator / result width
//   - LANES       : number of byte lanes per MAC word
//   - tail_mask() : valid-lane mask for the final, possibly partial, word
//   - words_of()  : number of MAC words needed for a byte count
// ---------------------------------------------------------------------------
package mnist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    localparam int ACC_W = 32'sd26;
    localparam int LANES = 32'sd4;

    // Lanes that carry real bytes in the last word; a full word lights all lanes.
    function automatic logic [LANES-1:0] tail_mask(input int unsigned n_bytes);
        logic [LANES-1:0] m;
        case (n_bytes % 32'd4)
            32'd1:   m = 4'b0001;
            32'd2:   m = 4'b0011;
            32'd3:   m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Ceiling division of a byte count into 4-byte MAC words.
    function automatic int unsigned words_of(input int unsigned n_bytes);
        return (n_bytes + 32'd3) / 32'd4;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer_if
// Control/result bundle between the layer sequencer and the four-lane MAC.
//   en       : MAC enable (one word per cycle)
//   flush    : restart accumulation on this word
//   valid    : per-lane valid mask
//   last_in  : final word of the current neuron
//   done     : MAC result-ready pulse
//   result   : signed accumulated result, valid with done
// Modports: master = sequencer side, slave = MAC side.
// ---------------------------------------------------------------------------
interface fc_layer_sequencer_if;
    import mnist_pkg::*;

    logic                    en;
    logic                    flush;
    logic [LANES-1:0]        valid;
    logic                    last_in;
    logic                    done;
    logic signed [ACC_W-1:0] result;

    modport master (
        output en, flush, valid, last_in,
        input  done, result
    );

    modport slave (
        input  en, flush, valid, last_in,
        output done, result
    );

endinterface

// File: rtl/fc_addr_gen.sv
// ---------------------------------------------------------------------------
// fc_addr_gen
// Word/neuron counters, running weight base and the one-cycle-delayed MAC
// control pipe for the layer sequencer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clear           : zero the counters at the start of a layer
//   issue           : issue word k of neuron n this cycle
//   advance         : step to the next neuron (k cleared, base += W)
//   k_last          : current word is the last word of a neuron
//   last_neuron     : current neuron is the last one in the layer
//   n               : current neuron index
//   feat_addr       : feature memory address (= k)
//   wgt_addr        : weight memory address (= base + k)
//   mac_en/flush/valid/last_in : MAC controls, one cycle behind the address
//                     so they line up with the 1-cycle memory read data
// ---------------------------------------------------------------------------
module fc_addr_gen
    import mnist_pkg::*;
#(
    parameter int unsigned IN_LEN      = 784,
    parameter int unsigned OUT_NEURONS = 10,
    parameter int unsigned FADDR_W     = 8,
    parameter int unsigned WADDR_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               issue,
    input  logic               advance,
    output logic               k_last,
    output logic               last_neuron,
    output logic [3:0]         n,
    output logic [FADDR_W-1:0] feat_addr,
    output logic [WADDR_W-1:0] wgt_addr,
    output logic               mac_en,
    output logic               mac_flush,
    output logic [LANES-1:0]   mac_valid,
    output logic               mac_last_in
);

    localparam int unsigned      W      = words_of(IN_LEN);
    localparam logic [FADDR_W-1:0] K_LAST = FADDR_W'(W - 32'd1);
    localparam logic [WADDR_W-1:0] W_STEP = WADDR_W'(W);
    localparam logic [3:0]         N_LAST = 4'(OUT_NEURONS - 32'd1);
    localparam logic [LANES-1:0]   TAIL   = tail_mask(IN_LEN);

    logic [FADDR_W-1:0] k_r;
    logic [3:0]         n_r;
    logic [WADDR_W-1:0] base_r;
    logic               en_r;
    logic               flush_r;
    logic [LANES-1:0]   valid_r;
    logic               last_r;

    assign k_last      = (k_r == K_LAST);
    assign last_neuron = (n_r == N_LAST);
    assign n           = n_r;
    assign feat_addr   = k_r;
    // Running base avoids an n*W multiplier.
    assign wgt_addr    = base_r + WADDR_W'(k_r);

    assign mac_en      = en_r;
    assign mac_flush   = flush_r;
    assign mac_valid   = valid_r;
    assign mac_last_in = last_r;

    // Word counter, neuron counter and running weight base.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r    <= '0;
            n_r    <= 4'd0;
            base_r <= '0;
        end else if (clear) begin
            k_r    <= '0;
            n_r    <= 4'd0;
            base_r <= '0;
        end else if (advance) begin
            k_r    <= '0;
            n_r    <= n_r + 4'd1;
            base_r <= base_r + W_STEP;
        end else if (issue) begin
            k_r    <= k_last ? '0 : k_r + FADDR_W'(1'b1);
        end
    end

    // MAC controls trail the issued address by one cycle (memory latency).
    always_ff @(posedge clk) begin
        if (rst) begin
            en_r    <= 1'b0;
            flush_r <= 1'b0;
            valid_r <= '0;
            last_r  <= 1'b0;
        end else begin
            en_r    <= issue;
            flush_r <= issue && (k_r == '0);
            last_r  <= issue && k_last;
            valid_r <= !issue ? '0 : (k_last ? TAIL : '1);
        end
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer
// Streams one fully-connected layer through the four-lane MAC, writes each
// neuron result to the result memory and tracks the running argmax.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a layer (ignored unless idle)
//   busy        : layer in progress
//   finish      : one-cycle completion pulse
//   error       : sticky MAC timeout flag, cleared by the next start
//   feat_addr   : feature memory read address
//   wgt_addr    : weight memory read address
//   mac         : MAC control/result bundle (master side)
//   res_we/res_addr/res_data : result memory write port
//   pred_class/pred_score    : argmax index and score
// ---------------------------------------------------------------------------
module fc_layer_sequencer
    import mnist_pkg::*;
#(
    parameter int unsigned IN_LEN      = 784,
    parameter int unsigned OUT_NEURONS = 10,
    parameter int unsigned FADDR_W     = 8,
    parameter int unsigned WADDR_W     = 12,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    finish,
    output logic                    error,
    output logic [FADDR_W-1:0]      feat_addr,
    output logic [WADDR_W-1:0]      wgt_addr,
    fc_layer_sequencer_if.master    mac,
    output logic                    res_we,
    output logic [3:0]              res_addr,
    output logic signed [ACC_W-1:0] res_data,
    output logic [3:0]              pred_class,
    output logic signed [ACC_W-1:0] pred_score
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT + 32'd1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'd1);

    seq_state_e              state_r;
    seq_state_e              state_next_s;
    logic                    clear_s;
    logic                    issue_s;
    logic                    advance_s;
    logic                    accept_s;
    logic                    timeout_s;
    logic                    k_last_s;
    logic                    last_neuron_s;
    logic [3:0]              n_s;
    logic [TMO_W-1:0]        tmo_r;
    logic signed [ACC_W-1:0] result_r;
    logic                    busy_r;
    logic                    finish_r;
    logic                    error_r;
    logic                    res_we_r;
    logic [3:0]              class_r;
    logic signed [ACC_W-1:0] score_r;
    logic                    en_s;
    logic                    flush_s;
    logic [LANES-1:0]        valid_s;
    logic                    last_in_s;

    fc_addr_gen #(
        .IN_LEN      (IN_LEN),
        .OUT_NEURONS (OUT_NEURONS),
        .FADDR_W     (FADDR_W),
        .WADDR_W     (WADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_s),
        .issue       (issue_s),
        .advance     (advance_s),
        .k_last      (k_last_s),
        .last_neuron (last_neuron_s),
        .n           (n_s),
        .feat_addr   (feat_addr),
        .wgt_addr    (wgt_addr),
        .mac_en      (en_s),
        .mac_flush   (flush_s),
        .mac_valid   (valid_s),
        .mac_last_in (last_in_s)
    );

    assign mac.en      = en_s;
    assign mac.flush   = flush_s;
    assign mac.valid   = valid_s;
    assign mac.last_in = last_in_s;

    assign busy       = busy_r;
    assign finish     = finish_r;
    assign error      = error_r;
    assign res_we     = res_we_r;
    assign res_addr   = n_s;
    assign res_data   = result_r;
    assign pred_class = class_r;
    assign pred_score = score_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        issue_s      = 1'b0;
        advance_s    = 1'b0;
        accept_s     = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clear_s      = 1'b1;
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                issue_s = 1'b1;
                if (k_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                // done wins over a timeout landing in the same cycle
                if (mac.done) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_WRITE;
                end else if (tmo_r == TMO_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_FINISH;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                if (last_neuron_s) begin
                    state_next_s = ST_FINISH;
                end else begin
                    advance_s    = 1'b1;
                    state_next_s = ST_STREAM;
                end
            end
            ST_FINISH: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Counts DRAIN cycles spent waiting for done; zero outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_r <= '0;
        end else if (state_r == ST_DRAIN) begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
        end else begin
            tmo_r <= '0;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
            res_we_r <= 1'b0;
        end else begin
            busy_r   <= (state_next_s == ST_STREAM) ||
                        (state_next_s == ST_DRAIN)  ||
                        (state_next_s == ST_WRITE);
            finish_r <= (state_next_s == ST_FINISH);
            res_we_r <= (state_next_s == ST_WRITE);
        end
    end

    // Result latch, sticky timeout flag and running argmax.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '0;
            error_r  <= 1'b0;
            class_r  <= 4'd0;
            score_r  <= '0;
        end else begin
            if (accept_s) begin
                result_r <= mac.result;
            end
            if (clear_s) begin
                error_r <= 1'b0;
            end else if (timeout_s) begin
                error_r <= 1'b1;
            end
            // Strictly-greater keeps the lowest index on ties.
            if (clear_s) begin
                class_r <= 4'd0;
                score_r <= '0;
            end else if ((state_r == ST_WRITE) &&
                         ((n_s == 4'd0) || (result_r > score_r))) begin
                class_r <= n_s;
                score_r <= result_r;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
module tb_fc_layer_sequencer;
    import mnist_pkg::*;

    localparam int unsigned IN_LEN = 10;
    localparam int unsigned OUT_N  = 3;
    localparam int unsigned FA     = 8;
    localparam int unsigned WA     = 12;
    localparam int unsigned TMO    = 64;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, finish, error;
    logic [FA-1:0] feat_addr;
    logic [WA-1:0] wgt_addr;
    logic res_we;
    logic [3:0] res_addr;
    logic signed [25:0] res_data;
    logic [3:0] pred_class;
    logic signed [25:0] pred_score;

    fc_layer_sequencer_if mac_bus ();

    fc_layer_sequencer #(
        .IN_LEN(IN_LEN), .OUT_NEURONS(OUT_N), .FADDR_W(FA), .WADDR_W(WA), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .finish(finish), .error(error),
        .feat_addr(feat_addr), .wgt_addr(wgt_addr), .mac(mac_bus), .res_we(res_we),
        .res_addr(res_addr), .res_data(res_data), .pred_class(pred_class), .pred_score(pred_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [25:0] res [3];
        int                 withhold;
        logic [3:0]         exp_class;
        logic signed [25:0] exp_score;
        logic               exp_error;
        int                 exp_writes;
    } vec_t;

    typedef struct {
        logic [7:0]  feat;
        logic [11:0] wgt;
        logic        flush;
        logic        last;
        logic [3:0]  valid;
    } word_t;

    typedef struct {
        logic [3:0]         addr;
        logic signed [25:0] data;
        int                 cyc;
    } wr_t;

    vec_t  vec [5];
    word_t wq [$];
    wr_t   rq [$];
    int    lastin_q [$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int run_id = 0, seen_id = 0, stray_id = 0, stray_seen = 0;
    int fin_cnt, fin_cyc, first_en_cyc, first_busy_cyc, err_rise_cyc;
    logic signed [25:0] cur_res [3];
    int cur_withhold = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // MAC model (fixed 4-cycle done latency) and output recorder.
    initial begin
        int cd, idx, model_n;
        logic err_prev, dn;
        logic [7:0] pf;
        logic [11:0] pw;
        cd = 0; idx = 0; model_n = 0; err_prev = 1'b0; pf = 8'd0; pw = 12'd0;
        mac_bus.done = 1'b0;
        mac_bus.result = 26'sd0;
        forever begin
            @(negedge clk);
            #1;
            if (run_id != seen_id) begin
                seen_id = run_id;
                wq.delete(); rq.delete(); lastin_q.delete();
                fin_cnt = 0; fin_cyc = -1; first_en_cyc = -1; first_busy_cyc = -1;
                err_rise_cyc = -1; model_n = 0; cd = 0;
            end
            if (rst) cd = 0;
            dn = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    dn = 1'b1;
                    mac_bus.result = cur_res[idx];
                end
            end
            if (mac_bus.en) begin
                wq.push_back('{pf, pw, mac_bus.flush, mac_bus.last_in, mac_bus.valid});
                if (first_en_cyc < 0) first_en_cyc = cyc;
            end
            if (mac_bus.last_in) begin
                lastin_q.push_back(cyc);
                if (model_n != cur_withhold && model_n < 3) begin
                    cd = 4;
                    idx = model_n;
                end
                model_n++;
            end
            if (stray_id != stray_seen) begin
                stray_seen = stray_id;
                dn = 1'b1;
                mac_bus.result = 26'sh0ABCDE;
            end
            mac_bus.done = dn;
            if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
            if (res_we) rq.push_back('{res_addr, res_data, cyc});
            if (finish) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
            if (error && !err_prev && err_rise_cyc < 0) err_rise_cyc = cyc;
            err_prev = error;
            pf = feat_addr;
            pw = wgt_addr;
        end
    end

    function automatic logic [127:0] outs_cat();
        return 128'({busy, finish, error, feat_addr, wgt_addr, mac_bus.en, mac_bus.flush,
                     mac_bus.valid, mac_bus.last_in, res_we, res_addr, res_data,
                     pred_class, pred_score});
    endfunction

    task automatic run_layer(input int vi, input bit disturb);
        int sc, nw, k;
        string t;
        t = $sformatf("v%0d%s", vi, disturb ? "d" : "");
        cur_res = vec[vi].res;
        cur_withhold = vec[vi].withhold;
        run_id++;
        @(negedge clk);
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            @(negedge clk);
            start = 1'b1;
            stray_id++;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 600 && fin_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);

        chk({t, "_finish_cnt"}, 128'(fin_cnt), 128'(1));
        chk({t, "_busy_after"}, 128'(busy), 128'(0));
        chk({t, "_first_busy"}, 128'(first_busy_cyc - sc), 128'(1));
        chk({t, "_first_en"}, 128'(first_en_cyc - sc), 128'(2));
        chk({t, "_n_writes"}, 128'(rq.size()), 128'(vec[vi].exp_writes));
        for (int i = 0; i < rq.size() && i < 3; i++) begin
            chk($sformatf("%s_wr%0d_addr", t, i), 128'(rq[i].addr), 128'(i));
            chk($sformatf("%s_wr%0d_data", t, i), 128'(rq[i].data), 128'(vec[vi].res[i]));
        end
        nw = (vec[vi].withhold < 0) ? 9 : 3 * (vec[vi].withhold + 1);
        chk({t, "_n_words"}, 128'(wq.size()), 128'(nw));
        for (int i = 0; i < wq.size() && i < 9; i++) begin
            k = i % 3;
            chk($sformatf("%s_word%0d", t, i),
                128'({wq[i].feat, wq[i].wgt, wq[i].flush, wq[i].last, wq[i].valid}),
                128'({8'(k), 12'(i), (k == 0), (k == 2), (k == 2) ? 4'b0011 : 4'b1111}));
        end
        chk({t, "_pred_class"}, 128'(pred_class), 128'(vec[vi].exp_class));
        chk({t, "_pred_score"}, 128'(pred_score), 128'(vec[vi].exp_score));
        chk({t, "_error"}, 128'(error), 128'(vec[vi].exp_error));
        if (!vec[vi].exp_error && rq.size() > 0 && lastin_q.size() > 0) begin
            chk({t, "_done_to_write"}, 128'(rq[0].cyc - lastin_q[0]), 128'(5));
            chk({t, "_write_to_finish"}, 128'(fin_cyc - rq[rq.size()-1].cyc), 128'(1));
        end else if (vec[vi].exp_error && lastin_q.size() > vec[vi].withhold) begin
            chk({t, "_timeout_cycles"}, 128'(err_rise_cyc - lastin_q[vec[vi].withhold]), 128'(TMO));
        end
    endtask

    initial begin
        vec[0].res = '{-26'sd5, 26'sd120, 26'sd37};
        vec[0].withhold = -1; vec[0].exp_class = 4'd1; vec[0].exp_score = 26'sd120;
        vec[0].exp_error = 1'b0; vec[0].exp_writes = 3;
        vec[1].res = '{-26'sd9, -26'sd9, -26'sd20};
        vec[1].withhold = -1; vec[1].exp_class = 4'd0; vec[1].exp_score = -26'sd9;
        vec[1].exp_error = 1'b0; vec[1].exp_writes = 3;
        vec[2].res = '{26'sd7, 26'sd7, 26'sd8};
        vec[2].withhold = -1; vec[2].exp_class = 4'd2; vec[2].exp_score = 26'sd8;
        vec[2].exp_error = 1'b0; vec[2].exp_writes = 3;
        vec[3].res = '{26'sd11, 26'sd50, 26'sd60};
        vec[3].withhold = 1; vec[3].exp_class = 4'd0; vec[3].exp_score = 26'sd11;
        vec[3].exp_error = 1'b1; vec[3].exp_writes = 1;
        vec[4].res = '{26'sd3, -26'sd2, 26'sd3};
        vec[4].withhold = -1; vec[4].exp_class = 4'd0; vec[4].exp_score = 26'sd3;
        vec[4].exp_error = 1'b0; vec[4].exp_writes = 3;

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_cat(), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) run_layer(v, 1'b0);

        // start and a stray done during STREAM must be ignored
        run_layer(0, 1'b1);

        // reset during DRAIN of the last neuron
        cur_res = vec[0].res;
        cur_withhold = -1;
        run_id++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && lastin_q.size() < 3; i++) @(negedge clk);
        chk("midrst_reached_drain", 128'(lastin_q.size()), 128'(3));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", outs_cat(), 128'd0);
        chk("midrst_writes", 128'(rq.size()), 128'(2));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        run_layer(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
